// File: rtl/anim_pkg.sv
// Shared animation identifiers, frame lengths and sequencer state encoding.
package anim_pkg;

   localparam logic [1:0] ANIM_IDLE  = 2'd0;
   localparam logic [1:0] ANIM_EAT   = 2'd1;
   localparam logic [1:0] ANIM_PLAY  = 2'd2;
   localparam logic [1:0] ANIM_SLEEP = 2'd3;

   // Frames per animation, indexed by anim_id; each must lie in 1..2**STEP_W.
   localparam int unsigned ANIM_LEN [4] = '{16, 8, 12, 6};

   typedef enum logic {S_IDLE, S_PLAY} state_e;

   function automatic int unsigned anim_len(input logic [1:0] id);
      return ANIM_LEN[id];
   endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame divider: one frame_tick pulse every 2**TICK_DIV clock cycles.
module frame_tick_gen #(
   parameter int unsigned TICK_DIV = 24
) (
   input  logic clk,
   input  logic rst,
   output logic frame_tick
);

   logic [TICK_DIV-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt <= '0;
      else      cnt <= cnt + 1'b1;
   end

   assign frame_tick = &cnt;

endmodule

// File: rtl/anim_sequencer.sv
// Shared frame sequencer: idle loops forever, requested one-shots play once with
// highest-index priority and preemption by higher requests.
module anim_sequencer
   import anim_pkg::*;
#(
   parameter int unsigned TICK_DIV = 24,
   parameter int unsigned N_ANIM   = 4,
   parameter int unsigned STEP_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_ANIM-1:0] req,
   input  logic              cancel,
   output logic [1:0]        anim_id,
   output logic [STEP_W-1:0] step,
   output logic              frame_tick,
   output logic [N_ANIM-1:0] ack,
   output logic              done,
   output logic              busy
);

   state_e              state;
   logic [N_ANIM-1:0]   pending;
   logic [1:0]          win;
   logic                any_pend;
   logic [STEP_W-1:0]   last_step;
   logic                tick_ok;
   logic                preempt;
   logic                finish;
   logic                start;

   frame_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick)
   );

   always_comb begin
      win = '0;
      for (int k = 1; k < N_ANIM; k++) begin
         if (pending[k]) win = 2'(k);
      end
   end

   assign any_pend  = |pending;
   assign last_step = STEP_W'(anim_len(anim_id) - 1);
   // Cancel suppresses every ack/done even when it lands on a frame boundary.
   assign tick_ok   = frame_tick & ~cancel;
   assign preempt   = (state == S_PLAY) && any_pend && (win > anim_id);
   assign finish    = (state == S_PLAY) && !preempt && (step == last_step);
   assign start     = tick_ok && any_pend && ((state == S_IDLE) || preempt || finish);
   assign done      = tick_ok && finish;

   always_comb begin
      ack = '0;
      if (start) ack[win] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         pending <= '0;
         anim_id <= ANIM_IDLE;
         step    <= '0;
         busy    <= 1'b0;
      end else if (cancel) begin
         state   <= S_IDLE;
         pending <= '0;
         anim_id <= ANIM_IDLE;
         step    <= '0;
         busy    <= 1'b0;
      end else begin
         // A request coinciding with its own ack re-arms the bit.
         pending <= (pending & ~ack) | (req & ~N_ANIM'(1));
         if (frame_tick) begin
            if (start) begin
               state   <= S_PLAY;
               anim_id <= win;
               step    <= '0;
               busy    <= 1'b1;
            end else if (state == S_IDLE) begin
               step <= (step == last_step) ? '0 : step + 1'b1;
            end else if (finish) begin
               state   <= S_IDLE;
               anim_id <= ANIM_IDLE;
               step    <= '0;
               busy    <= 1'b0;
            end else begin
               step <= step + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_anim_sequencer.sv
// Bench for anim_sequencer with TICK_DIV=2: cycle-level model plus directed scenarios.
module tb_anim_sequencer;

   localparam int TICKS = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic       cancel;
   logic [1:0] anim_id;
   logic [3:0] step;
   logic       frame_tick;
   logic [3:0] ack;
   logic       done;
   logic       busy;

   int errors = 0;
   int checks = 0;

   int         m_len [4] = '{16, 8, 12, 6};
   int         m_cnt, m_id, m_step, m_busy;
   logic [3:0] m_pend;

   anim_sequencer #(
      .TICK_DIV (2),
      .N_ANIM   (4),
      .STEP_W   (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .cancel     (cancel),
      .anim_id    (anim_id),
      .step       (step),
      .frame_tick (frame_tick),
      .ack        (ack),
      .done       (done),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Model: frame counter, current animation, pending set; evaluated once per cycle.
   always @(negedge clk) begin : model
      int         top;
      logic [3:0] e_ack;
      logic       e_done;
      logic       go;
      if (!rst) begin
         m_cnt = 0; m_id = 0; m_step = 0; m_busy = 0; m_pend = '0;
         check("reset_outputs", {anim_id, step, frame_tick, ack, done, busy}, 0);
      end else begin
         check("model_anim_id", anim_id, m_id);
         check("model_step", step, m_step);
         check("model_busy", busy, m_busy);
         check("model_tick", frame_tick, m_cnt == TICKS - 1);
         e_ack = '0; e_done = 1'b0; go = 1'b0;
         top = 0;
         for (int k = 1; k < 4; k++) if (m_pend[k]) top = k;
         if (cancel) begin
            m_pend = '0; m_id = 0; m_step = 0; m_busy = 0;
         end else begin
            if (m_cnt == TICKS - 1) begin
               if (m_busy == 0) begin
                  if (top != 0) go = 1'b1;
                  else m_step = (m_step + 1) % m_len[0];
               end else if (top > m_id) begin
                  go = 1'b1;
               end else if (m_step == m_len[m_id] - 1) begin
                  e_done = 1'b1;
                  if (top != 0) go = 1'b1;
                  else begin m_id = 0; m_step = 0; m_busy = 0; end
               end else begin
                  m_step = m_step + 1;
               end
               if (go) begin
                  e_ack[top] = 1'b1; m_pend[top] = 1'b0;
                  m_id = top; m_step = 0; m_busy = 1;
               end
            end
            for (int k = 1; k < 4; k++) if (req[k]) m_pend[k] = 1'b1;
         end
         m_cnt = (m_cnt + 1) % TICKS;
         check("model_ack", ack, e_ack);
         check("model_done", done, e_done);
      end
   end

   task automatic wait_tick();
      for (int i = 0; i < 2 * TICKS; i++) begin
         @(negedge clk);
         if (frame_tick) return;
      end
      check("tick_timeout", 0, 1);
   endtask

   task automatic pulse(input logic [3:0] r, input logic c);
      @(posedge clk); #1 req = r; cancel = c;
      @(posedge clk); #1 req = '0; cancel = 1'b0;
   endtask

   // Checks frames 0..n-1 of animation id; done and end_ack expected on frame len-1.
   task automatic play(input int id, input int len, input int n, input int end_ack);
      for (int f = 0; f < n; f++) begin
         wait_tick();
         check("play_anim_id", anim_id, id);
         check("play_step", step, f);
         check("play_busy", busy, 1);
         check("play_done", done, (f == len - 1) ? 1 : 0);
         if (f == len - 1) check("play_end_ack", ack, end_ack);
      end
   endtask

   task automatic expect_idle(input int s);
      wait_tick();
      check("idle_anim_id", anim_id, 0);
      check("idle_step", step, s);
      check("idle_busy", busy, 0);
      check("idle_ack", ack, 0);
      check("idle_done", done, 0);
   endtask

   initial begin
      rst = 1'b0; req = '0; cancel = 1'b0;
      repeat (3) @(posedge clk);
      #1 check("reset_step", step, 0);
      check("reset_busy", busy, 0);
      rst = 1'b1;

      // 1: idle loops 0..15 then wraps
      for (int n = 0; n < 18; n++) expect_idle(n % 16);

      // 2: single one-shot
      pulse(4'b0010, 1'b0);
      wait_tick();
      check("t2_ack", ack, 4'b0010);
      check("t2_idle_step", step, 2);
      play(1, 8, 8, 0);
      expect_idle(0);

      // 3: simultaneous requests, highest first then chained on the same tick
      pulse(4'b1010, 1'b0);
      wait_tick();
      check("t3_ack", ack, 4'b1000);
      play(3, 6, 6, 4'b0010);
      play(1, 8, 8, 0);
      expect_idle(0);

      // 4: preempt from step 3; lower request waits for completion
      pulse(4'b0010, 1'b0);
      wait_tick();
      check("t4_ack1", ack, 4'b0010);
      play(1, 8, 3, 0);
      pulse(4'b0100, 1'b0);
      wait_tick();
      check("t4_pre_step", step, 3);
      check("t4_pre_ack", ack, 4'b0100);
      check("t4_pre_done", done, 0);
      pulse(4'b0010, 1'b0);
      play(2, 12, 12, 4'b0010);
      play(1, 8, 8, 0);
      expect_idle(0);

      // 5: re-request on the acking tick plays twice
      @(posedge clk); #1 req = 4'b0100;
      @(posedge clk); #1 req = '0;
      @(posedge clk);
      @(posedge clk); #1 req = 4'b0100;
      @(posedge clk); #1 req = '0;
      play(2, 12, 12, 4'b0100);
      play(2, 12, 12, 0);
      expect_idle(0);

      // 6: cancel at step 5 drops pending; then async reset mid-play
      pulse(4'b1000, 1'b0);
      wait_tick();
      check("t6_ack", ack, 4'b1000);
      play(3, 6, 5, 0);
      pulse(4'b0010, 1'b0);
      @(posedge clk); #1 cancel = 1'b1;
      @(posedge clk); #1 cancel = 1'b0;
      check("t6_cancel_state", {anim_id, step, busy, ack, done}, 0);
      expect_idle(0);
      expect_idle(1);

      pulse(4'b0100, 1'b0);
      wait_tick();
      check("t6_ack2", ack, 4'b0100);
      play(2, 12, 2, 0);
      @(posedge clk); #2 rst = 1'b0;
      #1 check("t6_async_rst", {anim_id, step, frame_tick, ack, done, busy}, 0);
      @(posedge clk); #1 rst = 1'b1;
      expect_idle(0);
      expect_idle(1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
